// File: rtl/mp_port_rx.sv
// mp_port_rx: ingress receiver for one input port of the multi-port cache.
// Checks sop/eop framing, buffers words in a packet FIFO with a speculative
// write pointer, and only exposes whole, committed packets to the read side.
module mp_port_rx #(
   parameter int DATA_WIDTH   = 32,
   parameter int DEPTH        = 64,
   parameter int AFULL_MARGIN = 8,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                  clk,
   input  logic                  rst_n_in,
   input  logic                  wr_sop,
   input  logic                  wr_eop,
   input  logic                  wr_vld,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  ready,
   output logic                  rd_sop,
   output logic                  rd_eop,
   output logic                  rd_vld,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  full,
   output logic                  almost_full,
   output logic [CNT_WIDTH-1:0]  pkt_cnt,
   output logic [CNT_WIDTH-1:0]  drop_cnt
);

   localparam int AW  = $clog2(DEPTH);
   localparam int PW  = AW + 1;
   localparam int CW1 = CNT_WIDTH + 1;

   typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

   state_t        state_reg, state_next;
   logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
   logic [PW-1:0] cm_ptr_reg, cm_ptr_next;
   logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
   logic [PW-1:0] base_ptr, count_eff, count_next;
   logic          room, start_pkt, we, pop, pkt_inc;
   logic [1:0]    drop_inc;
   logic          sop_pend_reg;
   logic [CW1-1:0] drop_sum;

   // Word storage; bit DATA_WIDTH carries the eop flag of each word.
   logic [DATA_WIDTH:0] ram [DEPTH];

   // A sop arriving mid-packet rolls back to the commit point first, so the
   // room check for that word must be made against the rolled-back pointer.
   assign base_ptr  = (state_reg == RECV && wr_vld && wr_sop) ? cm_ptr_reg : wr_ptr_reg;
   assign count_eff = base_ptr - rd_ptr_reg;
   assign room      = (count_eff != PW'(DEPTH));
   assign pop       = ready && (rd_ptr_reg != cm_ptr_reg);
   assign rd_ptr_next = rd_ptr_reg + PW'(pop);
   assign count_next  = wr_ptr_next - rd_ptr_next;
   assign drop_sum    = {1'b0, drop_cnt} + CW1'(drop_inc);

   // Write-side framing FSM: next state, pointer updates and counter strobes.
   always_comb begin
      state_next  = state_reg;
      wr_ptr_next = wr_ptr_reg;
      cm_ptr_next = cm_ptr_reg;
      we          = 1'b0;
      start_pkt   = 1'b0;
      pkt_inc     = 1'b0;
      drop_inc    = 2'd0;
      if (wr_vld) begin
         case (state_reg)
            IDLE: begin
               if (wr_sop) start_pkt = 1'b1;
               else        drop_inc  = 2'd1;   // stray word outside a packet
            end
            RECV: begin
               if (wr_sop) begin
                  drop_inc  = 2'd1;            // abandon the unfinished packet
                  start_pkt = 1'b1;
               end else if (room) begin
                  we          = 1'b1;
                  wr_ptr_next = wr_ptr_reg + PW'(1);
                  if (wr_eop) begin
                     cm_ptr_next = wr_ptr_reg + PW'(1);
                     pkt_inc     = 1'b1;
                     state_next  = IDLE;
                  end
               end else begin
                  wr_ptr_next = cm_ptr_reg;
                  drop_inc    = 2'd1;
                  state_next  = wr_eop ? IDLE : DROP;
               end
            end
            DROP: begin
               if (wr_sop)      start_pkt  = 1'b1;
               else if (wr_eop) state_next = IDLE;
            end
            default: state_next = IDLE;
         endcase
      end
      if (start_pkt) begin
         if (room) begin
            we          = 1'b1;
            wr_ptr_next = base_ptr + PW'(1);
            if (wr_eop) begin
               cm_ptr_next = base_ptr + PW'(1);
               pkt_inc     = 1'b1;
               state_next  = IDLE;
            end else begin
               state_next  = RECV;
            end
         end else begin
            wr_ptr_next = cm_ptr_reg;
            drop_inc    = drop_inc + 2'd1;
            state_next  = wr_eop ? IDLE : DROP;
         end
      end
   end

   // State, pointers, status flags and saturating statistics.
   always_ff @(posedge clk) begin
      if (!rst_n_in) begin
         state_reg   <= IDLE;
         wr_ptr_reg  <= '0;
         cm_ptr_reg  <= '0;
         rd_ptr_reg  <= '0;
         full        <= 1'b0;
         almost_full <= 1'b0;
         pkt_cnt     <= '0;
         drop_cnt    <= '0;
      end else begin
         state_reg   <= state_next;
         wr_ptr_reg  <= wr_ptr_next;
         cm_ptr_reg  <= cm_ptr_next;
         rd_ptr_reg  <= rd_ptr_next;
         full        <= (count_next == PW'(DEPTH));
         almost_full <= ((DEPTH - int'(count_next)) <= AFULL_MARGIN);
         if (pkt_inc && pkt_cnt != '1)
            pkt_cnt <= pkt_cnt + CNT_WIDTH'(1);
         drop_cnt <= drop_sum[CNT_WIDTH] ? '1 : drop_sum[CNT_WIDTH-1:0];
      end
   end

   // RAM write port; stale contents are harmless since pointers gate reads.
   always_ff @(posedge clk) begin
      if (we)
         ram[base_ptr[AW-1:0]] <= {wr_eop, wr_data};
   end

   // Registered read port and output framing; rd_data holds between pops.
   always_ff @(posedge clk) begin
      if (!rst_n_in) begin
         rd_vld       <= 1'b0;
         rd_sop       <= 1'b0;
         rd_eop       <= 1'b0;
         rd_data      <= '0;
         sop_pend_reg <= 1'b1;
      end else begin
         rd_vld <= pop;
         rd_sop <= pop && sop_pend_reg;
         rd_eop <= pop && ram[rd_ptr_reg[AW-1:0]][DATA_WIDTH];
         if (pop) begin
            rd_data      <= ram[rd_ptr_reg[AW-1:0]][DATA_WIDTH-1:0];
            sop_pend_reg <= ram[rd_ptr_reg[AW-1:0]][DATA_WIDTH];
         end
      end
   end

endmodule

// File: tb/tb_mp_port_rx.sv
// Directed bench for mp_port_rx: framing, commit/rollback, overflow,
// back-pressure flags and reset behaviour with hand-computed expectations.
module tb_mp_port_rx;

   logic        clk;
   logic        rst_n_in;
   logic        wr_sop, wr_eop, wr_vld, ready;
   logic [31:0] wr_data;
   logic        rd_sop, rd_eop, rd_vld, full, almost_full;
   logic [31:0] rd_data;
   logic [15:0] pkt_cnt, drop_cnt;

   int checks   = 0;
   int failures = 0;
   logic seen_vld;

   mp_port_rx #(.DATA_WIDTH(32), .DEPTH(64), .AFULL_MARGIN(8), .CNT_WIDTH(16)) dut (
      .clk(clk), .rst_n_in(rst_n_in),
      .wr_sop(wr_sop), .wr_eop(wr_eop), .wr_vld(wr_vld), .wr_data(wr_data),
      .ready(ready),
      .rd_sop(rd_sop), .rd_eop(rd_eop), .rd_vld(rd_vld), .rd_data(rd_data),
      .full(full), .almost_full(almost_full),
      .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Apply one cycle of inputs; returns 1 time unit after the sampling edge.
   task automatic cyc(input logic s, input logic e, input logic v, input logic [31:0] d, input logic r);
      wr_sop = s; wr_eop = e; wr_vld = v; wr_data = d; ready = r;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n_in = 1'b0;
      cyc(0, 0, 0, 32'h0, 0);
      cyc(0, 0, 0, 32'h0, 0);
      rst_n_in = 1'b1;
   endtask

   initial begin
      rst_n_in = 1'b0;
      wr_sop = 0; wr_eop = 0; wr_vld = 0; wr_data = '0; ready = 0;

      // ---- reset state + 4-word packet
      do_reset();
      chk("rst_rd_vld", rd_vld, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_full", full, 0);
      chk("rst_afull", almost_full, 0);
      chk("rst_pkt_cnt", pkt_cnt, 0);
      chk("rst_drop_cnt", drop_cnt, 0);
      cyc(1, 0, 1, 32'hA0, 1);
      cyc(0, 0, 1, 32'hA1, 1);
      cyc(0, 0, 1, 32'hA2, 1);
      chk("t1_no_vld_uncommitted", rd_vld, 0);
      cyc(0, 1, 1, 32'hA3, 1);
      chk("t1_no_vld_commit_edge", rd_vld, 0);
      cyc(0, 0, 0, 0, 1);
      chk("t1_w0_vld", rd_vld, 1);
      chk("t1_w0_sop", rd_sop, 1);
      chk("t1_w0_eop", rd_eop, 0);
      chk("t1_w0_data", rd_data, 32'hA0);
      cyc(0, 0, 0, 0, 1);
      chk("t1_w1_vld", rd_vld, 1);
      chk("t1_w1_sop", rd_sop, 0);
      chk("t1_w1_data", rd_data, 32'hA1);
      cyc(0, 0, 0, 0, 1);
      chk("t1_w2_data", rd_data, 32'hA2);
      cyc(0, 0, 0, 0, 1);
      chk("t1_w3_vld", rd_vld, 1);
      chk("t1_w3_eop", rd_eop, 1);
      chk("t1_w3_data", rd_data, 32'hA3);
      cyc(0, 0, 0, 0, 1);
      chk("t1_end_vld", rd_vld, 0);
      chk("t1_end_data_hold", rd_data, 32'hA3);
      chk("t1_pkt_cnt", pkt_cnt, 1);

      // ---- single-word packet
      do_reset();
      cyc(1, 1, 1, 32'h5A, 1);
      chk("t2_no_vld_commit_edge", rd_vld, 0);
      cyc(0, 0, 0, 0, 1);
      chk("t2_vld", rd_vld, 1);
      chk("t2_sop", rd_sop, 1);
      chk("t2_eop", rd_eop, 1);
      chk("t2_data", rd_data, 32'h5A);
      cyc(0, 0, 0, 0, 1);
      chk("t2_one_word_only", rd_vld, 0);
      chk("t2_pkt_cnt", pkt_cnt, 1);

      // ---- aborted packet followed by a good one
      do_reset();
      cyc(1, 0, 1, 32'hB0, 1);
      cyc(0, 0, 1, 32'hB1, 1);
      cyc(0, 0, 1, 32'hB2, 1);
      cyc(1, 0, 1, 32'hC0, 1);
      chk("t3_abort_drop", drop_cnt, 1);
      chk("t3_abort_no_vld", rd_vld, 0);
      cyc(0, 1, 1, 32'hC1, 1);
      cyc(0, 0, 0, 0, 1);
      chk("t3_c0_vld", rd_vld, 1);
      chk("t3_c0_sop", rd_sop, 1);
      chk("t3_c0_data", rd_data, 32'hC0);
      cyc(0, 0, 0, 0, 1);
      chk("t3_c1_eop", rd_eop, 1);
      chk("t3_c1_data", rd_data, 32'hC1);
      cyc(0, 0, 0, 0, 1);
      chk("t3_end_vld", rd_vld, 0);
      chk("t3_pkt_cnt", pkt_cnt, 1);
      chk("t3_drop_cnt", drop_cnt, 1);

      // ---- 70-word packet overflows a 64-word FIFO
      do_reset();
      seen_vld = 1'b0;
      for (int i = 0; i < 70; i++) begin
         cyc(i == 0, i == 69, 1, 32'hD00 + i, 0);
         seen_vld = seen_vld | rd_vld;
         if (i == 54) chk("t4_afull_cnt55", almost_full, 0);
         if (i == 55) chk("t4_afull_cnt56", almost_full, 1);
         if (i == 62) chk("t4_full_cnt63", full, 0);
         if (i == 63) chk("t4_full_cnt64", full, 1);
         if (i == 64) begin
            chk("t4_ovf_full", full, 0);
            chk("t4_ovf_afull", almost_full, 0);
            chk("t4_ovf_drop", drop_cnt, 1);
         end
      end
      cyc(0, 0, 0, 0, 1);
      seen_vld = seen_vld | rd_vld;
      cyc(0, 0, 0, 0, 1);
      seen_vld = seen_vld | rd_vld;
      chk("t4_never_vld", seen_vld, 0);
      chk("t4_drop_cnt", drop_cnt, 1);
      chk("t4_pkt_cnt", pkt_cnt, 0);

      // ---- fill with 64 single-word packets, then pop one
      do_reset();
      for (int i = 0; i < 64; i++) begin
         cyc(1, 1, 1, 32'h100 + i, 0);
         if (i == 62) chk("t5_full_at63", full, 0);
      end
      chk("t5_full", full, 1);
      chk("t5_afull", almost_full, 1);
      chk("t5_pkt_cnt64", pkt_cnt, 64);
      cyc(0, 0, 0, 0, 1);
      chk("t5_pop_vld", rd_vld, 1);
      chk("t5_pop_data", rd_data, 32'h100);
      chk("t5_pop_sop", rd_sop, 1);
      chk("t5_pop_eop", rd_eop, 1);
      chk("t5_full_after_pop", full, 0);
      cyc(1, 1, 1, 32'h77, 0);
      chk("t5_refill_no_vld", rd_vld, 0);
      chk("t5_refull", full, 1);
      // push and pop together while full: pop proceeds, push is dropped
      cyc(1, 1, 1, 32'h88, 1);
      chk("t5_fullpush_vld", rd_vld, 1);
      chk("t5_fullpush_data", rd_data, 32'h101);
      chk("t5_fullpush_drop", drop_cnt, 1);
      chk("t5_fullpush_full", full, 0);
      chk("t5_pkt_cnt65", pkt_cnt, 65);

      // ---- stray words, then reset mid-packet
      do_reset();
      cyc(0, 0, 1, 32'h1, 1);
      cyc(0, 1, 1, 32'h2, 1);
      cyc(0, 0, 1, 32'h3, 1);
      chk("t6_stray_drop", drop_cnt, 3);
      cyc(0, 0, 0, 0, 1);
      chk("t6_stray_no_vld", rd_vld, 0);
      chk("t6_stray_pkt", pkt_cnt, 0);
      cyc(1, 1, 1, 32'h66, 1);
      cyc(0, 0, 0, 0, 1);
      chk("t6_pre_data", rd_data, 32'h66);
      cyc(1, 1, 1, 32'h67, 0);
      cyc(1, 0, 1, 32'h68, 0);
      rst_n_in = 1'b0;
      cyc(0, 0, 0, 0, 0);
      rst_n_in = 1'b1;
      chk("t6_rst_vld", rd_vld, 0);
      chk("t6_rst_sop", rd_sop, 0);
      chk("t6_rst_eop", rd_eop, 0);
      chk("t6_rst_data", rd_data, 0);
      chk("t6_rst_full", full, 0);
      chk("t6_rst_afull", almost_full, 0);
      chk("t6_rst_pkt", pkt_cnt, 0);
      chk("t6_rst_drop", drop_cnt, 0);
      cyc(1, 0, 1, 32'hF0, 1);
      chk("t6_old_data_gone", rd_vld, 0);
      cyc(0, 0, 1, 32'hF1, 1);
      cyc(0, 1, 1, 32'hF2, 1);
      cyc(0, 0, 0, 0, 1);
      chk("t6_f0_sop", rd_sop, 1);
      chk("t6_f0_data", rd_data, 32'hF0);
      cyc(0, 0, 0, 0, 1);
      chk("t6_f1_data", rd_data, 32'hF1);
      cyc(0, 0, 0, 0, 1);
      chk("t6_f2_eop", rd_eop, 1);
      chk("t6_f2_data", rd_data, 32'hF2);
      cyc(0, 0, 0, 0, 1);
      chk("t6_end_vld", rd_vld, 0);
      chk("t6_pkt_cnt", pkt_cnt, 1);
      chk("t6_drop_cnt", drop_cnt, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
